// File: rtl/leopard_divide_bank.sv
// Multi-channel programmable clock divider for the PSG tone path.
// Each channel toggles a square-wave bit every (div+1) enabled ce cycles and pulses tick.
module leopard_divide_bank #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DIV_WIDTH = 12,
    parameter int unsigned CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 ce,
    input  logic [CHANNELS-1:0]  enable,
    input  logic [CHANNELS-1:0]  restart,
    input  logic                 wr_en,
    input  logic [CHAN_W-1:0]    wr_chan,
    input  logic [DIV_WIDTH-1:0] wr_data,
    output logic [CHANNELS-1:0]  state,
    output logic [CHANNELS-1:0]  tick
);

    localparam logic [CHAN_W:0] ChanCount = (CHAN_W+1)'(CHANNELS);

    logic wr_ok;

    // Out-of-range channel selects must not alias onto a real channel.
    assign wr_ok = wr_en && ({1'b0, wr_chan} < ChanCount);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [DIV_WIDTH-1:0] div_q, div_d;
        logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
        logic                 state_q, state_d;
        logic                 tick_q, tick_d;
        logic                 wr_hit;

        assign wr_hit = wr_ok && (wr_chan == CHAN_W'(g));

        always_comb begin
            div_d   = wr_hit ? wr_data : div_q;
            cnt_d   = cnt_q;
            state_d = state_q;
            tick_d  = 1'b0;
            // Reloads use div_q so a same-cycle write only lands at the following reload.
            if (restart[g]) begin
                cnt_d   = div_q;
                state_d = 1'b0;
            end else if (enable[g] && ce) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d   = div_q;
                    state_d = ~state_q;
                    tick_d  = 1'b1;
                end
            end
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                div_q   <= '0;
                cnt_q   <= '0;
                state_q <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                div_q   <= div_d;
                cnt_q   <= cnt_d;
                state_q <= state_d;
                tick_q  <= tick_d;
            end
        end

        assign state[g] = state_q;
        assign tick[g]  = tick_q;
    end

endmodule

// File: tb/tb_leopard_divide_bank.sv
// Scoreboard bench for leopard_divide_bank: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_leopard_divide_bank;

    logic        aclk;
    logic        areset;
    logic        ce;
    logic [3:0]  enable;
    logic [3:0]  restart;
    logic        wr_en;
    logic [1:0]  wr_chan;
    logic [11:0] wr_data;
    logic [3:0]  state;
    logic [3:0]  tick;

    // Three-channel instance so an out-of-range channel select is representable.
    logic        ce3;
    logic [2:0]  enable3;
    logic [2:0]  restart3;
    logic        wr_en3;
    logic [1:0]  wr_chan3;
    logic [3:0]  wr_data3;
    logic [2:0]  state3;
    logic [2:0]  tick3;

    leopard_divide_bank #(.CHANNELS(4), .DIV_WIDTH(12)) u_dut (
        .aclk    (aclk),
        .areset  (areset),
        .ce      (ce),
        .enable  (enable),
        .restart (restart),
        .wr_en   (wr_en),
        .wr_chan (wr_chan),
        .wr_data (wr_data),
        .state   (state),
        .tick    (tick)
    );

    leopard_divide_bank #(.CHANNELS(3), .DIV_WIDTH(4)) u_dut3 (
        .aclk    (aclk),
        .areset  (areset),
        .ce      (ce3),
        .enable  (enable3),
        .restart (restart3),
        .wr_en   (wr_en3),
        .wr_chan (wr_chan3),
        .wr_data (wr_data3),
        .state   (state3),
        .tick    (tick3)
    );

    typedef struct {
        int         cyc;
        int         unit;
        logic [3:0] mask;
        logic [3:0] st;
        logic [3:0] tk;
        string      name;
    } exp_t;

    exp_t       sbq[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         mi;
    logic [3:0] act_s;
    logic [3:0] act_t;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Monitor: compare every expectation due this cycle; anything overdue is a miss.
    always @(negedge aclk) begin
        mi = 0;
        while (mi < sbq.size()) begin
            if (sbq[mi].cyc <= cyc) begin
                act_s = (sbq[mi].unit == 0) ? state : {1'b0, state3};
                act_t = (sbq[mi].unit == 0) ? tick  : {1'b0, tick3};
                total++;
                if (sbq[mi].cyc != cyc) begin
                    bad++;
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                             sbq[mi].name, sbq[mi].cyc, cyc);
                end else if (((act_s & sbq[mi].mask) !== (sbq[mi].st & sbq[mi].mask)) ||
                             ((act_t & sbq[mi].mask) !== (sbq[mi].tk & sbq[mi].mask))) begin
                    bad++;
                    $display("FAIL %s cyc=%0d mask=%b state got=%b want=%b tick got=%b want=%b",
                             sbq[mi].name, cyc, sbq[mi].mask, act_s & sbq[mi].mask,
                             sbq[mi].st & sbq[mi].mask, act_t & sbq[mi].mask,
                             sbq[mi].tk & sbq[mi].mask);
                end
                sbq.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_one(input string name, input int unit, input int at,
                            input logic [3:0] mask, input logic [3:0] st, input logic [3:0] tk);
        exp_t e;
        e.cyc  = at;
        e.unit = unit;
        e.mask = mask;
        e.st   = st;
        e.tk   = tk;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Hand-written '0'/'1' strings: character k is the expected value k cycles from now.
    task automatic push_seq(input string name, input int unit, input logic [3:0] mask,
                            input string st, input string tk);
        for (int k = 0; k < st.len(); k++)
            push_one(name, unit, cyc + k, mask,
                     (st[k] == "1") ? mask : 4'b0, (tk[k] == "1") ? mask : 4'b0);
    endtask

    task automatic push_const(input string name, input int unit, input logic [3:0] mask,
                              input logic [3:0] st, input logic [3:0] tk, input int n);
        for (int k = 0; k < n; k++) push_one(name, unit, cyc + k, mask, st, tk);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [11:0] data);
        wr_en   = 1'b1;
        wr_chan = ch;
        wr_data = data;
        cycle();
        wr_en   = 1'b0;
    endtask

    task automatic rst_pulse(input logic [3:0] m);
        restart = m;
        cycle();
        restart = 4'b0;
    endtask

    task automatic cleanup();
        enable  = 4'b0;
        ce      = 1'b0;
        restart = 4'hF;
        cycle();
        restart = 4'b0;
        cycle();
    endtask

    initial begin
        areset   = 1'b1;
        ce       = 1'b0;
        enable   = 4'b0;
        restart  = 4'b0;
        wr_en    = 1'b0;
        wr_chan  = 2'd0;
        wr_data  = 12'd0;
        ce3      = 1'b0;
        enable3  = 3'b0;
        restart3 = 3'b0;
        wr_en3   = 1'b0;
        wr_chan3 = 2'd0;
        wr_data3 = 4'd0;

        // Reset defaults
        repeat (3) cycle();
        push_const("in_reset", 0, 4'hF, 4'h0, 4'h0, 1);
        areset = 1'b0;
        push_const("after_reset", 0, 4'hF, 4'h0, 4'h0, 20);
        repeat (20) cycle();

        // Legacy divide-by-2: D=0 everywhere
        enable = 4'hF;
        ce     = 1'b1;
        push_seq("legacy", 0, 4'hF, "01010101", "01111111");
        repeat (7) cycle();
        cleanup();

        // Divide by 8 on ch1, other channels untouched
        wr(2'd1, 12'd3);
        rst_pulse(4'b0010);
        enable = 4'b0010;
        ce     = 1'b1;
        push_seq("div8_ch1", 0, 4'b0010, "0000111100001111", "0000100010001000");
        push_const("div8_others", 0, 4'b1101, 4'h0, 4'h0, 16);
        repeat (15) cycle();
        cleanup();

        // Mid-period write on ch0: D=7 then D=1 three cycles after the first toggle
        wr(2'd0, 12'd7);
        rst_pulse(4'b0001);
        enable = 4'b0001;
        ce     = 1'b1;
        push_seq("midwrite_ch0", 0, 4'b0001,
                 "0000000011111111001100", "0000000010000000101010");
        for (int k = 0; k < 22; k++) begin
            wr_en   = (k == 10);
            wr_chan = 2'd0;
            wr_data = 12'd1;
            cycle();
        end
        wr_en = 1'b0;
        cleanup();

        // Gating on ch2: D=1, ce every other cycle, enable dropped for 10 cycles
        wr(2'd2, 12'd1);
        rst_pulse(4'b0100);
        push_seq("gate_ch2", 0, 4'b0100,
                 "000111100001111111111111100", "000100010001000000000000010");
        push_const("gate_others", 0, 4'b1011, 4'h0, 4'h0, 27);
        for (int j = 0; j < 27; j++) begin
            ce     = (j % 2 == 0);
            enable = (j >= 12 && j < 22) ? 4'b0000 : 4'b0100;
            cycle();
        end
        cleanup();

        // Out-of-range write on the 3-channel instance must leave every divisor at 0
        wr_en3   = 1'b1;
        wr_chan3 = 2'd3;
        wr_data3 = 4'd5;
        cycle();
        wr_en3  = 1'b0;
        enable3 = 3'b111;
        ce3     = 1'b1;
        push_seq("oob_write", 1, 4'b0111, "0101010", "0111111");
        repeat (7) cycle();
        enable3 = 3'b0;

        // Same-cycle restart and write on ch3: reload uses old D=2, then D=6
        wr(2'd3, 12'd2);
        restart = 4'b1000;
        wr_en   = 1'b1;
        wr_chan = 2'd3;
        wr_data = 12'd6;
        cycle();
        restart = 4'b0;
        wr_en   = 1'b0;
        enable  = 4'b1000;
        ce      = 1'b1;
        push_seq("rst_wr_ch3", 0, 4'b1000, "000111111100", "000100000010");
        push_const("rst_wr_others", 0, 4'b0111, 4'h0, 4'h0, 12);
        repeat (11) cycle();
        cleanup();

        // Maximum divisor on ch0: half-period 4096 clocks
        wr(2'd0, 12'hFFF);
        rst_pulse(4'b0001);
        enable = 4'b0001;
        ce     = 1'b1;
        push_one("max_k0",    0, cyc,        4'b0001, 4'b0000, 4'b0000);
        push_one("max_k1",    0, cyc + 1,    4'b0001, 4'b0000, 4'b0000);
        push_one("max_k2048", 0, cyc + 2048, 4'b0001, 4'b0000, 4'b0000);
        push_one("max_k4095", 0, cyc + 4095, 4'b0001, 4'b0000, 4'b0000);
        push_one("max_k4096", 0, cyc + 4096, 4'b0001, 4'b0001, 4'b0001);
        push_one("max_k4097", 0, cyc + 4097, 4'b0001, 4'b0001, 4'b0000);
        push_one("max_k8191", 0, cyc + 8191, 4'b0001, 4'b0001, 4'b0000);
        push_one("max_k8192", 0, cyc + 8192, 4'b0001, 4'b0000, 4'b0001);
        repeat (8193) cycle();
        cleanup();

        // Asynchronous reset mid-count with D=5 on ch1
        wr(2'd1, 12'd5);
        rst_pulse(4'b0010);
        enable = 4'b0010;
        ce     = 1'b1;
        push_seq("d5_run", 0, 4'b0010, "0000001", "0000001");
        repeat (7) cycle();
        areset = 1'b1;
        push_one("async_clear", 0, cyc, 4'hF, 4'h0, 4'h0);
        cycle();
        // Divisor was cleared, so the first enabled ce cycle toggles at once
        areset = 1'b0;
        push_seq("post_reset_ch1", 0, 4'b0010, "0101", "0111");
        repeat (4) cycle();
        cleanup();

        repeat (3) cycle();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: pending expectations got=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
